// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv_pkg
//  Purpose  : Shared types and helpers for the sliding-window 1-D convolution
//             engine: FSM state encoding and signed saturation helpers.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

  typedef enum logic [1:0] {
    LOAD_F = 2'd0,
    FILL   = 2'd1,
    MAC    = 2'd2,
    OUT    = 2'd3
  } state_t;

  // Helpers work on a 64-bit signed carrier, so data widths up to 31 bits
  // are supported (a full product must fit in the carrier).
  function automatic logic signed [63:0] MAXV(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] MINV(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  // Clamp a sign-extended value into the signed range of 'width' bits.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] value,
                                               input int width);
    if (value > MAXV(width)) begin
      return MAXV(width);
    end else if (value < MINV(width)) begin
      return MINV(width);
    end
    return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_sat_mac.sv
`default_nettype none
// ============================================================================
//  Module   : conv_sat_mac
//  Purpose  : Combinational multiply-accumulate step with two saturations:
//             the full-width product is clamped to WIDTH, then the WIDTH+1
//             bit sum with the accumulator is clamped to WIDTH again.
//  Ports    : w_i    - window sample for the current tap
//             coef_i - coefficient for the current tap
//             acc_i  - current accumulator
//             acc_o  - next accumulator value
//  Revision : 1.0 - initial release
// ============================================================================
module conv_sat_mac
  import conv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] w_i,
  input  logic signed [WIDTH-1:0] coef_i,
  input  logic signed [WIDTH-1:0] acc_i,
  output logic signed [WIDTH-1:0] acc_o
);

  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [63:0]        w_prod_ext;
  logic signed [WIDTH-1:0]   w_prod_sat;
  logic signed [WIDTH:0]     w_sum;
  logic signed [63:0]        w_sum_ext;

  // Operands are sign-extended to the product width explicitly so the
  // multiply is exact regardless of context sizing.
  assign w_prod = $signed({{WIDTH{w_i[WIDTH-1]}}, w_i}) *
                  $signed({{WIDTH{coef_i[WIDTH-1]}}, coef_i});

  assign w_prod_ext = {{(64-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
  assign w_prod_sat = WIDTH'(sat_w(w_prod_ext, WIDTH));

  assign w_sum = {acc_i[WIDTH-1], acc_i} + {w_prod_sat[WIDTH-1], w_prod_sat};

  assign w_sum_ext = {{(63-WIDTH){w_sum[WIDTH]}}, w_sum};
  assign acc_o     = WIDTH'(sat_w(w_sum_ext, WIDTH));

endmodule
`default_nettype wire

// File: rtl/conv_stream_sliding.sv
`default_nettype none
// ============================================================================
//  Module   : conv_stream_sliding
//  Purpose  : Streaming 1-D convolution y[k] = sum_j x[k+j]*f[j] over an
//             M-deep sliding window, with run-time loaded coefficients,
//             per-step saturation and optional ReLU clamp on the output.
//  Ports    : clk / reset          - clock, async active-low reset
//             s_*_f                - coefficient stream (ready/valid)
//             s_*_x                - sample stream (ready/valid)
//             m_*_y                - result stream (ready/valid)
//             cfg_relu             - 1 = clamp negative results to zero
//  Revision : 1.0 - initial release
// ============================================================================
module conv_stream_sliding
  import conv_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int LOGN  = $clog2(N+1),
  parameter int LOGM  = $clog2(M+1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_in_f,
  input  logic                    s_valid_f,
  output logic                    s_ready_f,
  input  logic signed [WIDTH-1:0] s_data_in_x,
  input  logic                    s_valid_x,
  output logic                    s_ready_x,
  output logic signed [WIDTH-1:0] m_data_out_y,
  output logic                    m_valid_y,
  input  logic                    m_ready_y,
  input  logic                    cfg_relu
);

  localparam logic [LOGM-1:0] c_FILL_FULL = LOGM'(M);
  localparam logic [LOGM-1:0] c_FILL_WAIT = LOGM'(M-1);
  localparam logic [LOGM-1:0] c_LAST_TAP  = LOGM'(M-1);
  localparam logic [LOGN-1:0] c_LAST_Y    = LOGN'(N-M+1);
  localparam logic [LOGN-1:0] c_X_OWED    = LOGN'(N-M);

  state_t                  state_q, state_d;
  logic [LOGM-1:0]         fcnt_q, fcnt_d;
  logic [LOGM-1:0]         fill_q, fill_d;
  logic [LOGM-1:0]         tap_q, tap_d;
  logic [LOGN-1:0]         ocnt_q, ocnt_d;
  logic                    xin_q, xin_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic signed [WIDTH-1:0] y_q, y_d;
  logic                    yv_q, yv_d;
  logic signed [WIDTH-1:0] coef_q [M];
  logic signed [WIDTH-1:0] win_q  [M];

  logic                    w_f_xfer, w_x_xfer, w_y_xfer;
  logic                    w_coef_we, w_win_shift, w_win_clr;
  logic [LOGM-1:0]         w_coef_idx;
  logic [LOGN-1:0]         w_ocnt_inc;
  logic signed [WIDTH-1:0] w_acc_next;

  // Ready decode. At a vector boundary a pending coefficient beat wins, so
  // the sample stream is held off while s_valid_f is up there.
  assign s_ready_f = reset &&
                     ((state_q == LOAD_F) || ((state_q == FILL) && (fill_q == '0)));
  assign s_ready_x = reset &&
                     (((state_q == FILL) && (fill_q != c_FILL_FULL) &&
                       !((fill_q == '0) && s_valid_f)) ||
                      ((state_q == OUT) && (ocnt_q < c_X_OWED) && !xin_q));

  assign w_f_xfer   = s_valid_f && s_ready_f;
  assign w_x_xfer   = s_valid_x && s_ready_x;
  assign w_y_xfer   = yv_q && m_ready_y;
  assign w_ocnt_inc = ocnt_q + LOGN'(1);

  assign m_data_out_y = y_q;
  assign m_valid_y    = yv_q;

  conv_sat_mac #(.WIDTH(WIDTH)) u_mac (
    .w_i    (win_q[tap_q]),
    .coef_i (coef_q[tap_q]),
    .acc_i  (acc_q),
    .acc_o  (w_acc_next)
  );

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    fill_d      = fill_q;
    tap_d       = tap_q;
    ocnt_d      = ocnt_q;
    xin_d       = xin_q;
    acc_d       = acc_q;
    y_d         = y_q;
    yv_d        = yv_q;
    w_coef_we   = 1'b0;
    w_coef_idx  = fcnt_q;
    w_win_shift = 1'b0;
    w_win_clr   = 1'b0;

    case (state_q)
      LOAD_F: begin
        if (w_f_xfer) begin
          w_coef_we = 1'b1;
          if (fcnt_q == c_LAST_TAP) begin
            state_d = FILL;
            fcnt_d  = '0;
            fill_d  = '0;
          end else begin
            fcnt_d = fcnt_q + LOGM'(1);
          end
        end
      end

      FILL: begin
        if (w_f_xfer) begin
          // The beat that opens a reload is already coefficient 0.
          w_coef_we  = 1'b1;
          w_coef_idx = '0;
          fcnt_d     = LOGM'(1);
          state_d    = LOAD_F;
        end else if (fill_q == c_FILL_FULL) begin
          state_d = MAC;
          fill_d  = '0;
          tap_d   = '0;
          acc_d   = '0;
        end else if (w_x_xfer) begin
          w_win_shift = 1'b1;
          fill_d      = fill_q + LOGM'(1);
        end
      end

      MAC: begin
        acc_d = w_acc_next;
        if (tap_q == c_LAST_TAP) begin
          state_d = OUT;
          tap_d   = '0;
          y_d     = (cfg_relu && w_acc_next[WIDTH-1]) ? '0 : w_acc_next;
          yv_d    = 1'b1;
        end else begin
          tap_d = tap_q + LOGM'(1);
        end
      end

      OUT: begin
        if (w_x_xfer) begin
          w_win_shift = 1'b1;
          xin_d       = 1'b1;
        end
        if (w_y_xfer) begin
          yv_d = 1'b0;
          if (w_ocnt_inc == c_LAST_Y) begin
            state_d   = FILL;
            fill_d    = '0;
            ocnt_d    = '0;
            xin_d     = 1'b0;
            w_win_clr = 1'b1;
          end else begin
            ocnt_d = w_ocnt_inc;
            if (xin_q || w_x_xfer) begin
              state_d = MAC;
              tap_d   = '0;
              acc_d   = '0;
              xin_d   = 1'b0;
            end else begin
              state_d = FILL;
              fill_d  = c_FILL_WAIT;
            end
          end
        end
      end

      default: state_d = LOAD_F;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD_F;
      fcnt_q  <= '0;
      fill_q  <= '0;
      tap_q   <= '0;
      ocnt_q  <= '0;
      xin_q   <= 1'b0;
      acc_q   <= '0;
      y_q     <= '0;
      yv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      fill_q  <= fill_d;
      tap_q   <= tap_d;
      ocnt_q  <= ocnt_d;
      xin_q   <= xin_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
    end
  end

  // Window: w[M-1] holds the newest sample, w[0] the oldest.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < M; i++) begin
        coef_q[i] <= '0;
        win_q[i]  <= '0;
      end
    end else begin
      if (w_coef_we) begin
        coef_q[w_coef_idx] <= s_data_in_f;
      end
      if (w_win_clr) begin
        for (int i = 0; i < M; i++) begin
          win_q[i] <= '0;
        end
      end else if (w_win_shift) begin
        for (int i = 0; i < M-1; i++) begin
          win_q[i] <= win_q[i+1];
        end
        win_q[M-1] <= s_data_in_x;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_stream_sliding.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_stream_sliding
//  Purpose  : Directed self-checking bench for conv_stream_sliding
//             (WIDTH=8, N=8, M=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_stream_sliding;

  logic              clk;
  logic              reset;
  logic signed [7:0] s_data_in_f;
  logic              s_valid_f;
  logic              s_ready_f;
  logic signed [7:0] s_data_in_x;
  logic              s_valid_x;
  logic              s_ready_x;
  logic signed [7:0] m_data_out_y;
  logic              m_valid_y;
  logic              m_ready_y;
  logic              cfg_relu;

  conv_stream_sliding #(.WIDTH(8), .N(8), .M(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_data_in_f  (s_data_in_f),
    .s_valid_f    (s_valid_f),
    .s_ready_f    (s_ready_f),
    .s_data_in_x  (s_data_in_x),
    .s_valid_x    (s_valid_x),
    .s_ready_x    (s_ready_x),
    .m_data_out_y (m_data_out_y),
    .m_valid_y    (m_valid_y),
    .m_ready_y    (m_ready_y),
    .cfg_relu     (cfg_relu)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  int xq[$];
  int yq[$];
  int ytake[$];
  int rises[$];
  int x_sent   = 0;
  int x4_edge  = -100;
  int x_gap    = 0;
  bit y_rand   = 0;
  bit x_took   = 0;
  bit prev_v   = 0;
  bit mac_watch = 0;
  int mac_viol = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Observe handshakes half a cycle before the edge that completes them.
  always @(negedge clk) begin
    x_took = s_valid_x && s_ready_x;
    if (m_valid_y && m_ready_y) begin
      yq.push_back(int'(m_data_out_y));
      ytake.push_back(cyc + 1);
    end
    if (m_valid_y && !prev_v) rises.push_back(cyc);
    prev_v = m_valid_y;
    if (mac_watch && cyc > x4_edge && cyc <= x4_edge + 4 && s_ready_x) mac_viol++;
  end

  // Sample source: offers queued samples, optional random idle gaps.
  initial begin : x_source
    int gap;
    gap = 0;
    s_valid_x = 1'b0;
    s_data_in_x = '0;
    forever begin
      @(posedge clk); #1;
      if (x_took && xq.size() > 0) begin
        void'(xq.pop_front());
        x_sent++;
        if (x_sent == 4) x4_edge = cyc;
        s_valid_x = 1'b0;
        if (x_gap > 0) gap = $urandom_range(0, x_gap);
      end
      x_took = 1'b0;
      if (!s_valid_x) begin
        if (gap > 0) gap--;
        else if (xq.size() > 0) begin
          s_valid_x = 1'b1;
          s_data_in_x = 8'(xq[0]);
        end
      end
    end
  end

  initial begin : y_sink
    forever begin
      @(posedge clk); #1;
      if (y_rand) m_ready_y = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_f(input int v);
    int b;
    b = 0;
    s_data_in_f = 8'(v);
    s_valid_f = 1'b1;
    do begin
      @(negedge clk);
      b++;
    end while (!s_ready_f && b < 200);
    if (!s_ready_f) check_eq("f_handshake", 0, 1);
    @(posedge clk); #1;
    s_valid_f = 1'b0;
  endtask

  task automatic load_f(input int f0, input int f1, input int f2, input int f3);
    send_f(f0); send_f(f1); send_f(f2); send_f(f3);
  endtask

  task automatic push_ramp();
    for (int i = 1; i <= 8; i++) xq.push_back(i);
  endtask

  task automatic wait_y(input int n);
    int b;
    b = 0;
    while (yq.size() < n && b < 3000) begin
      tick(1);
      b++;
    end
    check_eq("y_count", yq.size(), n);
  endtask

  task automatic new_test();
    yq.delete(); ytake.delete(); rises.delete();
    x_sent = 0;
  endtask

  task automatic check_five(input string tag, input int y0, input int step);
    for (int i = 0; i < 5 && i < yq.size(); i++)
      check_eq($sformatf("%s_y%0d", tag, i), yq[i], y0 + i * step);
  endtask

  initial begin : main
    int xs0;
    int bad;
    int b;
    reset = 1'b0;
    s_valid_f = 1'b0;
    s_data_in_f = '0;
    m_ready_y = 1'b0;
    cfg_relu = 1'b0;
    tick(3);

    // Reset state
    check_eq("rst_ready_f", int'(s_ready_f), 0);
    check_eq("rst_ready_x", int'(s_ready_x), 0);
    check_eq("rst_valid_y", int'(m_valid_y), 0);
    check_eq("rst_data_y", int'(m_data_out_y), 0);
    reset = 1'b1;
    #1;
    check_eq("post_rst_ready_f", int'(s_ready_f), 1);

    // Basic vector, latency, MAC gating, exact counts
    new_test();
    mac_watch = 1'b1;
    m_ready_y = 1'b1;
    load_f(1, 2, 3, 4);
    push_ramp();
    wait_y(5);
    check_five("basic", 30, 10);
    check_eq("first_y_latency", (rises.size() > 0) ? rises[0] - x4_edge : -1, 5);
    tick(20);
    mac_watch = 1'b0;
    check_eq("mac_ready_x_low", mac_viol, 0);
    check_eq("basic_y_total", yq.size(), 5);
    check_eq("basic_x_total", x_sent, 8);
    check_eq("boundary_ready_f", int'(s_ready_f), 1);

    // Product saturation, positive and negative
    new_test();
    load_f(2, 0, 0, 0);
    xq.push_back(100);
    for (int i = 0; i < 7; i++) xq.push_back(0);
    wait_y(5);
    check_eq("psat_pos_y0", yq[0], 127);
    check_eq("psat_pos_y1", yq[1], 0);
    new_test();
    load_f(-2, 0, 0, 0);
    xq.push_back(100);
    for (int i = 0; i < 7; i++) xq.push_back(0);
    wait_y(5);
    check_eq("psat_neg_y0", yq[0], -128);

    // Negative results, signed and with ReLU
    new_test();
    load_f(-1, -1, -1, -1);
    push_ramp();
    wait_y(5);
    check_five("neg", -10, -4);
    new_test();
    cfg_relu = 1'b1;
    push_ramp();
    wait_y(5);
    check_five("relu", 0, 0);
    cfg_relu = 1'b0;

    // Accumulator saturation
    new_test();
    load_f(127, 127, 127, 127);
    for (int i = 0; i < 8; i++) xq.push_back(127);
    wait_y(5);
    check_five("asat", 127, 0);

    // Back-pressure on y[1]
    new_test();
    load_f(1, 2, 3, 4);
    push_ramp();
    b = 0;
    while (yq.size() < 1 && b < 500) begin tick(1); b++; end
    m_ready_y = 1'b0;
    b = 0;
    while (!m_valid_y && b < 50) begin tick(1); b++; end
    xs0 = x_sent;
    bad = 0;
    repeat (20) begin
      tick(1);
      if (!m_valid_y || m_data_out_y !== 8'sd40) bad++;
    end
    check_eq("stall_stable", bad, 0);
    check_eq("stall_one_x", x_sent - xs0, 1);
    check_eq("stall_ready_x", int'(s_ready_x), 0);
    m_ready_y = 1'b1;
    wait_y(5);
    check_five("bp", 30, 10);
    check_eq("release_latency",
             (rises.size() > 2 && ytake.size() > 1) ? rises[2] - ytake[1] : -1, 4);

    // Random gaps over three vectors, coefficient reload at the boundary
    new_test();
    x_gap = 3;
    y_rand = 1'b1;
    load_f(1, 2, 3, 4);
    push_ramp();
    wait_y(5);
    load_f(4, 3, 2, 1);
    push_ramp();
    push_ramp();
    wait_y(15);
    for (int i = 0; i < 15 && i < yq.size(); i++)
      check_eq($sformatf("rand_y%0d", i), yq[i],
               (i < 5) ? 30 + 10 * i : 20 + 10 * (i % 5));
    y_rand = 1'b0;
    x_gap = 0;
    tick(1);
    m_ready_y = 1'b1;

    // Asynchronous reset in the middle of MAC for y[2]
    new_test();
    load_f(1, 2, 3, 4);
    push_ramp();
    b = 0;
    while (yq.size() < 2 && b < 500) begin tick(1); b++; end
    tick(1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_valid_y", int'(m_valid_y), 0);
    check_eq("arst_ready_x", int'(s_ready_x), 0);
    check_eq("arst_ready_f", int'(s_ready_f), 0);
    check_eq("arst_data_y", int'(m_data_out_y), 0);
    xq.delete();
    s_valid_x = 1'b0;
    tick(2);
    reset = 1'b1;
    #1;
    check_eq("arst_rel_ready_f", int'(s_ready_f), 1);
    check_eq("arst_rel_ready_x", int'(s_ready_x), 0);
    new_test();
    push_ramp();
    tick(4);
    check_eq("no_x_before_f", x_sent, 0);
    load_f(1, 0, 0, 0);
    wait_y(5);
    check_five("after_rst", 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
